// File: rtl/prng_mc.sv
// prng_mc: multi-channel multiplicative congruential generator.
// Each result is rand = (operand * a) mod m, computed by an MSB-first shift-add
// modular multiplier. Latency is WIDTH+3 clocks regardless of operand values.
// Optional feature: define PRNG_MC_STREAM_EN to add a `stream` input that chains
// results back-to-back on the same channel without returning to idle.
// The result port is rand_val because `rand` is a reserved word.
module prng_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 4,
  localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] seed,
  input  logic [CHW-1:0]   ch,
  input  logic             start,
  input  logic             cont,
`ifdef PRNG_MC_STREAM_EN
  input  logic             stream,
`endif
  output logic             done,
  output logic [WIDTH-1:0] rand_val,
  output logic [CHW-1:0]   rand_ch,
  output logic             err
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned EW = WIDTH + 2;

  typedef enum logic [2:0] {StIdle, StLoad, StMul, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [CHW-1:0]   ch_q, ch_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             err_pend_q, err_pend_d;
  logic [WIDTH-1:0] rand_q, rand_d;
  logic [CHW-1:0]   rand_ch_q, rand_ch_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] chan_q [NCH];
  logic [WIDTH-1:0] chan_d [NCH];

  // Scratch values for the datapath; extra two bits keep 2*acc + op from overflowing.
  logic [CHW-1:0]   ch_sel;
  logic [WIDTH-1:0] m_sel;
  logic [WIDTH-1:0] raw;
  logic             bad;
  logic [EW-1:0]    m_ext;
  logic [EW-1:0]    dbl;
  logic [EW-1:0]    sum;
  logic [WIDTH-1:0] res;

`ifdef PRNG_MC_STREAM_EN
  // strm_q marks a LOAD entered from DONE via stream: reuse latched m, a, ch.
  logic strm_q, strm_d;

  // Stream-chaining flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strm_q <= 1'b0;
    end else begin
      strm_q <= strm_d;
    end
  end
`else
  localparam logic strm_q = 1'b0;
`endif

  // State and datapath registers; channel states reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      m_q        <= '0;
      a_q        <= '0;
      ch_q       <= '0;
      op_q       <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      err_pend_q <= 1'b0;
      rand_q     <= '0;
      rand_ch_q  <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NCH; i++) chan_q[i] <= WIDTH'(1);
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      a_q        <= a_d;
      ch_q       <= ch_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      err_pend_q <= err_pend_d;
      rand_q     <= rand_d;
      rand_ch_q  <= rand_ch_d;
      err_q      <= err_d;
      chan_q     <= chan_d;
    end
  end

  // Next-state logic for the FSM and the modular multiplier.
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    a_d        = a_q;
    ch_d       = ch_q;
    op_d       = op_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    err_pend_d = err_pend_q;
    rand_d     = rand_q;
    rand_ch_d  = rand_ch_q;
    err_d      = err_q;
    chan_d     = chan_q;
`ifdef PRNG_MC_STREAM_EN
    strm_d     = strm_q;
`endif
    ch_sel = strm_q ? ch_q : ch;
    m_sel  = strm_q ? m_q : m;
    raw    = (cont || strm_q) ? chan_q[ch_sel] : seed;
    bad    = (raw == '0) || (raw >= m_sel);
    m_ext  = {2'b00, m_q};
    dbl    = {1'b0, acc_q, 1'b0};
    if (dbl >= m_ext) dbl = dbl - m_ext;
    sum    = dbl + (a_q[idx_q] ? {2'b00, op_q} : '0);
    if (sum >= m_ext) sum = sum - m_ext;
    res    = (acc_q >= m_q) ? acc_q - m_q : acc_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
`ifdef PRNG_MC_STREAM_EN
          strm_d  = 1'b0;
`endif
        end
      end
      StLoad: begin
        m_d        = m_sel;
        a_d        = strm_q ? a_q : a;
        ch_d       = ch_sel;
        op_d       = bad ? WIDTH'(1) : raw;
        err_pend_d = bad;
        acc_d      = '0;
        idx_d      = IW'(WIDTH - 1);
        state_d    = StMul;
      end
      StMul: begin
        acc_d = WIDTH'(sum);
        if (idx_q == '0) begin
          state_d = StFix;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StFix: begin
        rand_d         = res;
        rand_ch_d      = ch_q;
        err_d          = err_pend_q;
        chan_d[ch_q]   = res;
        state_d        = StDone;
      end
      StDone: begin
`ifdef PRNG_MC_STREAM_EN
        if (stream) begin
          state_d = StLoad;
          strm_d  = 1'b1;
        end else if (!start) begin
          state_d = StIdle;
        end
`else
        if (!start) state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  assign done     = (state_q == StDone);
  assign rand_val = rand_q;
  assign rand_ch  = rand_ch_q;
  assign err      = err_q;

endmodule

// File: tb/tb_prng_mc.sv
// tb_prng_mc: directed bench for prng_mc with a behavioural (op*a mod m) model
// per channel and a per-cycle compare process on the result outputs.
module tb_prng_mc;

  localparam logic [31:0] M = 32'd2147483647;
  localparam logic [31:0] A = 32'd16807;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m, a, seed;
  logic [1:0]  ch;
  logic        start, cont;
  logic        done;
  logic [31:0] rand_val;
  logic [1:0]  rand_ch;
  logic        err;

  logic [15:0] m16, a16, seed16;
  logic [1:0]  ch16;
  logic        start16, cont16, done16, err16;
  logic [15:0] rand16;
  logic [1:0]  rand_ch16;

`ifdef PRNG_MC_STREAM_EN
  logic stream;
`endif

  always #5 clk = ~clk;

  prng_mc u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m        (m),
    .a        (a),
    .seed     (seed),
    .ch       (ch),
    .start    (start),
    .cont     (cont),
`ifdef PRNG_MC_STREAM_EN
    .stream   (stream),
`endif
    .done     (done),
    .rand_val (rand_val),
    .rand_ch  (rand_ch),
    .err      (err)
  );

  prng_mc #(.WIDTH(16)) u_dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .m        (m16),
    .a        (a16),
    .seed     (seed16),
    .ch       (ch16),
    .start    (start16),
    .cont     (cont16),
`ifdef PRNG_MC_STREAM_EN
    .stream   (1'b0),
`endif
    .done     (done16),
    .rand_val (rand16),
    .rand_ch  (rand_ch16),
    .err      (err16)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mstate [4];
  logic [31:0] exp_rand;
  int          exp_ch;
  logic        exp_err;
  logic        cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [31:0] lcg(input logic [31:0] x);
    return 32'((64'(x) * 64'(A)) % 64'(M));
  endfunction

  // Whenever a result is presented, it must match the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cmp_en && done) begin
      check("cmp_rand", rand_val, exp_rand);
      check("cmp_ch", rand_ch, exp_ch);
      check("cmp_err", err, exp_err);
    end
  end

  task automatic run_op(input int c, input bit cn, input logic [31:0] sd,
                        input int drop_at, input int hold, input bit scramble);
    logic [31:0] op;
    bit          bad;
    int          lat;
    bit          seen;
    op  = cn ? mstate[c] : sd;
    bad = (op == 0) || (op >= M);
    if (bad) op = 32'd1;
    exp_rand  = lcg(op);
    exp_err   = bad;
    exp_ch    = c;
    mstate[c] = exp_rand;
    cmp_en    = 1'b1;
    @(negedge clk);
    ch = 2'(c); cont = cn; seed = sd; start = 1'b1;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == drop_at) start = 1'b0;
      if (scramble && lat == 4) begin
        m = $urandom; a = $urandom; seed = $urandom; ch = ~ch; cont = ~cont;
      end
      if (lat < 35) check("done_early", done, 0);
      seen = done;
    end
    check("latency", lat, 35);
    m = M; a = A;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("done_hold", done, 1);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("done_fall", done, 0);
    check("rand_idle_hold", rand_val, exp_rand);
  endtask

  initial begin
    rst_n = 1'b0; m = M; a = A; seed = '0; ch = '0; start = 1'b0; cont = 1'b0;
    m16 = '0; a16 = '0; seed16 = '0; ch16 = '0; start16 = 1'b0; cont16 = 1'b0;
`ifdef PRNG_MC_STREAM_EN
    stream = 1'b0;
`endif
    for (int i = 0; i < 4; i++) mstate[i] = 32'd1;

    // Pin the model with literal values.
    begin
      logic [31:0] x;
      x = 32'd1;
      for (int i = 0; i < 10000; i++) x = lcg(x);
      check("model_10000", x, 32'd1043618065);
      check("model_1", lcg(32'd1), 32'd16807);
      check("model_2", lcg(32'd16807), 32'd282475249);
      check("model_seed", lcg(32'h7B818935), 32'h755735EB);
    end

    repeat (3) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_rand", rand_val, 0);
    check("rst_ch", rand_ch, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    run_op(0, 1'b0, 32'd1, 0, 0, 1'b0);
    check("ch0_r1", rand_val, 32'd16807);
    check("ch0_r1_ch", rand_ch, 0);
    check("ch0_r1_err", err, 0);
    run_op(0, 1'b1, 32'd0, 6, 0, 1'b0);
    check("ch0_r2", rand_val, 32'd282475249);
    run_op(0, 1'b1, 32'd0, 0, 4, 1'b0);
    check("ch0_r3", rand_val, 32'd1622650073);
    run_op(1, 1'b1, 32'd0, 0, 0, 1'b0);
    check("ch1_untouched", rand_val, 32'd16807);
    check("ch1_ch", rand_ch, 1);
    run_op(0, 1'b0, 32'h7B818935, 0, 0, 1'b1);
    check("seed_hex", rand_val, 32'h755735EB);
    run_op(0, 1'b0, 32'd0, 0, 0, 1'b0);
    check("seed0_rand", rand_val, 32'd16807);
    check("seed0_err", err, 1);
    run_op(3, 1'b0, M, 0, 0, 1'b0);
    check("seed_eq_m_err", err, 1);
    run_op(3, 1'b0, 32'hFFFF_FFFF, 0, 0, 1'b0);
    check("seed_big_err", err, 1);
    check("seed_big_rand", rand_val, 32'd16807);

    for (int i = 0; i < 200; i++) run_op(2, 1'b1, 32'd0, 0, 0, 1'b0);
    check("ch2_chain", rand_val, mstate[2]);

    // Abort mid-multiply with reset.
    cmp_en = 1'b0;
    @(negedge clk);
    ch = 2'd0; cont = 1'b1; start = 1'b1;
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0; start = 1'b0;
    #1;
    check("abort_done", done, 0);
    check("abort_rand", rand_val, 0);
    check("abort_ch", rand_ch, 0);
    check("abort_err", err, 0);
    for (int i = 0; i < 4; i++) mstate[i] = 32'd1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_idle", done, 0);
    run_op(0, 1'b1, 32'd0, 0, 0, 1'b0);
    check("after_rst_ch0", rand_val, 32'd16807);
    run_op(2, 1'b1, 32'd0, 0, 0, 1'b0);
    check("after_rst_ch2", rand_val, 32'd16807);

    // 16-bit instance.
    begin
      int lat;
      @(negedge clk);
      m16 = 16'd65521; a16 = 16'd17; seed16 = 16'd65520; ch16 = 2'd0; cont16 = 1'b0;
      start16 = 1'b1;
      lat = 0;
      while (!done16 && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      check("w16_latency", lat, 19);
      check("w16_rand", rand16, 16'd65504);
      check("w16_err", err16, 0);
      @(negedge clk);
      start16 = 1'b0;
    end

`ifdef PRNG_MC_STREAM_EN
    begin
      logic [31:0] sv;
      int e, last_e, k;
      bit prev;
      cmp_en = 1'b0;
      @(negedge clk);
      ch = 2'd3; cont = 1'b0; seed = 32'd1; stream = 1'b1; start = 1'b1;
      sv = 32'd1; e = 0; last_e = 0; k = 0; prev = 1'b0;
      while (k < 3 && e < 300) begin
        @(posedge clk); #1;
        e++;
        if (prev && k < 3) check("stream_pulse_w", done, 0);
        prev = 1'b0;
        if (done) begin
          sv = lcg(sv);
          check("stream_rand", rand_val, sv);
          check("stream_gap", e - last_e, 35);
          last_e = e;
          k++;
          if (k == 3) stream = 1'b0;
          else prev = 1'b1;
        end
      end
      check("stream_count", k, 3);
      check("stream_third", rand_val, 32'd1622650073);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      check("stream_idle", done, 0);
      mstate[3] = sv;
    end
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
